// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: synchronises rst_req, stretches the reset, then releases
// channels in index order GAP cycles apart; per-channel soft resets are honoured only in RUN.
module reset_sequencer #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int STRETCH     = 8,
   parameter int GAP         = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rst_req,
   input  logic [N_CH-1:0] sw_rst,
   output logic [N_CH-1:0] rst_out,
   output logic            all_released,
   output logic            busy
);

   localparam int MAX_SG = (STRETCH > GAP) ? STRETCH : GAP;
   localparam int MAX_V  = (MAX_SG > N_CH) ? MAX_SG : N_CH;
   localparam int CW     = $clog2(MAX_V + 1);

   localparam logic [CW-1:0] STRETCH_C  = CW'(STRETCH);
   localparam logic [CW-1:0] GAP_C      = CW'(GAP);
   localparam logic [CW-1:0] LAST_IDX_C = CW'(N_CH - 1);
   localparam logic [CW-1:0] ONE_C      = CW'(1);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_RELEASE,
      ST_RUN
   } state_t;

   state_t                state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]         hold_cnt_q, hold_cnt_d;
   logic [CW-1:0]         gap_cnt_q, gap_cnt_d;
   logic [CW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         soft_cnt_q [N_CH];
   logic [CW-1:0]         soft_cnt_d [N_CH];
   logic [N_CH-1:0]       rst_out_q, rst_out_d;
   logic                  all_released_q, all_released_d;
   logic                  busy_q, busy_d;
   logic                  req_s;

   // Stage 0 takes the raw request; the MSB is the synchronised level.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], rst_req};
   assign req_s  = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      idx_d      = idx_q;
      rst_out_d  = rst_out_q;
      soft_cnt_d = soft_cnt_q;

      case (state_q)
         ST_HOLD: begin
            rst_out_d = '1;
            if (req_s) begin
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + ONE_C;
               if (hold_cnt_d == STRETCH_C) begin
                  hold_cnt_d = '0;
                  gap_cnt_d  = '0;
                  if (GAP == 0 || N_CH == 1) begin
                     rst_out_d = '0;
                     idx_d     = '0;
                     state_d   = ST_RUN;
                  end else begin
                     rst_out_d[0] = 1'b0;
                     idx_d        = ONE_C;
                     state_d      = ST_RELEASE;
                  end
               end
            end
         end

         ST_RELEASE: begin
            if (req_s) begin
               state_d    = ST_HOLD;
               rst_out_d  = '1;
               hold_cnt_d = '0;
               gap_cnt_d  = '0;
               idx_d      = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + ONE_C;
               if (gap_cnt_d == GAP_C) begin
                  gap_cnt_d = '0;
                  for (int i = 0; i < N_CH; i++) begin
                     if (CW'(i) == idx_q) rst_out_d[i] = 1'b0;
                  end
                  if (idx_q == LAST_IDX_C) begin
                     idx_d   = '0;
                     state_d = ST_RUN;
                  end else begin
                     idx_d = idx_q + ONE_C;
                  end
               end
            end
         end

         ST_RUN: begin
            if (req_s) begin
               state_d    = ST_HOLD;
               rst_out_d  = '1;
               hold_cnt_d = '0;
               gap_cnt_d  = '0;
               idx_d      = '0;
               for (int i = 0; i < N_CH; i++) soft_cnt_d[i] = '0;
            end else begin
               // Soft counter counts down the remaining reset cycles; 1->0 releases.
               for (int i = 0; i < N_CH; i++) begin
                  if (sw_rst[i]) begin
                     rst_out_d[i]  = 1'b1;
                     soft_cnt_d[i] = STRETCH_C;
                  end else if (soft_cnt_q[i] != '0) begin
                     soft_cnt_d[i] = soft_cnt_q[i] - ONE_C;
                     if (soft_cnt_q[i] == ONE_C) rst_out_d[i] = 1'b0;
                  end
               end
            end
         end

         default: begin
            state_d    = ST_HOLD;
            rst_out_d  = '1;
            hold_cnt_d = '0;
            gap_cnt_d  = '0;
            idx_d      = '0;
            for (int i = 0; i < N_CH; i++) soft_cnt_d[i] = '0;
         end
      endcase

      all_released_d = (state_d == ST_RUN) && (rst_out_d == '0);
      busy_d         = (state_d != ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_HOLD;
         sync_q         <= '1;
         hold_cnt_q     <= '0;
         gap_cnt_q      <= '0;
         idx_q          <= '0;
         for (int i = 0; i < N_CH; i++) soft_cnt_q[i] <= '0;
         rst_out_q      <= '1;
         all_released_q <= 1'b0;
         busy_q         <= 1'b1;
      end else begin
         state_q        <= state_d;
         sync_q         <= sync_d;
         hold_cnt_q     <= hold_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         idx_q          <= idx_d;
         for (int i = 0; i < N_CH; i++) soft_cnt_q[i] <= soft_cnt_d[i];
         rst_out_q      <= rst_out_d;
         all_released_q <= all_released_d;
         busy_q         <= busy_d;
      end
   end

   assign rst_out      = rst_out_q;
   assign all_released = all_released_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default config plus GAP=0 and N_CH=1 variants.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       rst_req;
   logic [3:0] sw_rst;
   logic [3:0] sw_g0;
   logic       sw_n1;

   logic [3:0] rst_out;
   logic       all_released, busy;
   logic [3:0] rst_out_g0;
   logic       all_released_g0, busy_g0;
   logic       rst_out_n1;
   logic       all_released_n1, busy_n1;

   int tests_run    = 0;
   int tests_failed = 0;
   int edge_n       = 0;

   always #5 clk = ~clk;

   reset_sequencer #(.N_CH(4), .SYNC_STAGES(2), .STRETCH(8), .GAP(4)) dut (
      .clk(clk), .rst(rst), .rst_req(rst_req), .sw_rst(sw_rst),
      .rst_out(rst_out), .all_released(all_released), .busy(busy)
   );

   reset_sequencer #(.N_CH(4), .SYNC_STAGES(2), .STRETCH(8), .GAP(0)) dut_g0 (
      .clk(clk), .rst(rst), .rst_req(rst_req), .sw_rst(sw_g0),
      .rst_out(rst_out_g0), .all_released(all_released_g0), .busy(busy_g0)
   );

   reset_sequencer #(.N_CH(1), .SYNC_STAGES(2), .STRETCH(8), .GAP(4)) dut_n1 (
      .clk(clk), .rst(rst), .rst_req(rst_req), .sw_rst(sw_n1),
      .rst_out(rst_out_n1), .all_released(all_released_n1), .busy(busy_n1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
      end
   endtask

   // Release schedule after rst drops: channels clear at edges 10, 14, 18, 22.
   function automatic logic [3:0] exp_boot(input int e);
      if (e < 10)      return 4'b1111;
      else if (e < 14) return 4'b1110;
      else if (e < 18) return 4'b1100;
      else if (e < 22) return 4'b1000;
      else             return 4'b0000;
   endfunction

   initial begin
      logic [3:0] exp4;

      rst = 1'b1; rst_req = 1'b0; sw_rst = '0; sw_g0 = '0; sw_n1 = 1'b0;
      repeat (3) tick();
      check("rst_rst_out", rst_out, 4'b1111);
      check("rst_all_rel", all_released, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_g0_out", rst_out_g0, 4'b1111);
      check("rst_n1_out", rst_out_n1, 1'b1);
      check("rst_n1_busy", busy_n1, 1'b1);

      // Boot sequence; a sw_rst burst during HOLD must be ignored.
      rst = 1'b0;
      edge_n = 0;
      for (int e = 1; e <= 22; e++) begin
         sw_rst = (e == 5) ? 4'b1111 : 4'b0000;
         tick();
         check("boot_out", rst_out, exp_boot(e));
         check("boot_busy", busy, (e < 22));
         check("boot_all_rel", all_released, (e >= 22));
         check("g0_out", rst_out_g0, (e < 10) ? 4'b1111 : 4'b0000);
         check("g0_all_rel", all_released_g0, (e >= 10));
         check("n1_out", rst_out_n1, (e < 10));
         check("n1_busy", busy_n1, (e < 10));
      end
      sw_rst = '0;

      // Single-cycle soft pulse on channel 2 (and N_CH=1 channel 0).
      sw_rst = 4'b0100; sw_n1 = 1'b1;
      tick();
      sw_rst = '0; sw_n1 = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) tick();
         check("soft_out", rst_out, (k < 8) ? 4'b0100 : 4'b0000);
         check("soft_all_rel", all_released, (k >= 8));
         check("soft_busy", busy, 1'b0);
         check("soft_n1_out", rst_out_n1, (k < 8));
      end

      // Retrigger channel 1 at +5 together with a fresh pulse on channel 0.
      sw_rst = 4'b0010;
      tick();
      sw_rst = '0;
      for (int k = 1; k <= 13; k++) begin
         sw_rst = (k == 5) ? 4'b0011 : 4'b0000;
         tick();
         if (k < 5)       exp4 = 4'b0010;
         else if (k < 13) exp4 = 4'b0011;
         else             exp4 = 4'b0000;
         check("retrig_out", rst_out, exp4);
      end
      sw_rst = '0;

      // rst_req held 50 cycles from RUN.
      rst_req = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         tick();
         check("hold50_out", rst_out, (k < 3) ? 4'b0000 : 4'b1111);
         check("hold50_busy", busy, (k >= 3));
      end
      rst_req = 1'b0;
      for (int k = 51; k <= 64; k++) begin
         tick();
         if (k < 60)      exp4 = 4'b1111;
         else if (k < 64) exp4 = 4'b1110;
         else             exp4 = 4'b1100;
         check("hold50_rel", rst_out, exp4);
      end

      // Two-cycle rst_req pulse during RELEASE after channel 1 released.
      rst_req = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         if (k == 3) rst_req = 1'b0;
         tick();
         if (k < 3)       exp4 = 4'b1100;
         else if (k < 12) exp4 = 4'b1111;
         else             exp4 = 4'b1110;
         check("pulse_out", rst_out, exp4);
         check("pulse_busy", busy, 1'b1);
      end

      repeat (12) tick();
      check("rerun_out", rst_out, 4'b0000);
      check("rerun_all_rel", all_released, 1'b1);

      // Synchronous rst in the middle of a soft-reset count.
      sw_rst = 4'b1000;
      tick();
      sw_rst = '0;
      tick();
      check("softmid_out", rst_out, 4'b1000);
      check("softmid_all_rel", all_released, 1'b0);
      rst = 1'b1;
      tick();
      check("rst_mid_out", rst_out, 4'b1111);
      check("rst_mid_all_rel", all_released, 1'b0);
      check("rst_mid_busy", busy, 1'b1);
      rst = 1'b0;
      edge_n = 0;
      for (int e = 1; e <= 30; e++) begin
         tick();
         check("reboot_out", rst_out, exp_boot(e));
         check("reboot_all_rel", all_released, (e >= 22));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
